mul_wb_buffer: RTL and testbench

MUL_WB_BUFFER -- requirements
Module: mul_wb_buffer

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_wb_sext.sv | 12 +
 rtl/mul_wb_buffer.sv | 102 ++++++++++
 tb/tb_mul_wb_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier writeback types and helpers.
// Word sign extension is used by mul_wb_buffer only when MUL_WB_WORD_EN is defined.
package mul_pkg;

  localparam int XLEN         = 64;
  localparam int TAGW_DEFAULT = 5;

  typedef struct packed {
    logic [XLEN-1:0]         data;
    logic [TAGW_DEFAULT-1:0] rd;
  } mul_wb_entry_t;

  // RV64 W-form results are the low word sign-extended to XLEN.
  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/mul_wb_sext.sv
// W-form result sign extension; instantiated by mul_wb_buffer under MUL_WB_WORD_EN.
module mul_wb_sext
  import mul_pkg::*;
(
  input  logic [XLEN-1:0] product,
  input  logic            word,
  output logic [XLEN-1:0] data
);

  assign data = word ? sext_word(product[31:0]) : product;

endmodule

// File: rtl/mul_wb_buffer.sv
// Result FIFO between the multiplier and register writeback; drops x0 results.
// Define MUL_WB_WORD_EN to sign-extend W-form products on entry.
module mul_wb_buffer
  import mul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = TAGW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_product,
  input  logic [TAGW-1:0]            in_rd,
  input  logic                       in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_data,
  output logic [TAGW-1:0]            out_rd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  mul_wb_entry_t mem_q [DEPTH];
  mul_wb_entry_t mem_d [DEPTH];
  mul_wb_entry_t head_entry;

  logic [XLEN-1:0] wr_data;
  logic            push;
  logic            pop;

`ifdef MUL_WB_WORD_EN
  mul_wb_sext u_sext (
    .product (in_product),
    .word    (in_word),
    .data    (wr_data)
  );
`else
  logic unused_in_word;
  assign unused_in_word = in_word;
  assign wr_data        = in_product;
`endif

  // Handshake signals depend only on registered occupancy.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // An x0 result completes its handshake but never occupies an entry.
  assign push = in_valid && in_ready && (in_rd != '0);
  assign pop  = out_valid && out_ready;

  assign head_entry = mem_q[head_q];
  assign out_data   = out_valid ? head_entry.data : '0;
  assign out_rd     = out_valid ? TAGW'(head_entry.rd) : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q].data = wr_data;
        mem_d[tail_q].rd   = TAGW_DEFAULT'(in_rd);
        tail_d             = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Self-checking bench for mul_wb_buffer against a queue-based reference model.
// Expected word-mode data follows MUL_WB_WORD_EN, matching the RTL build.
module tb_mul_wb_buffer;

  localparam int DEPTH = 2;
  localparam int TAGW  = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_product;
  logic [TAGW-1:0] in_rd;
  logic            in_word;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [TAGW-1:0] out_rd;
  logic [CW-1:0]   count;

  typedef struct {
    logic [63:0]     d;
    logic [TAGW-1:0] rd;
  } ent_t;

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;

  mul_wb_buffer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_rd      (in_rd),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_value(input logic [63:0] p, input logic w);
`ifdef MUL_WB_WORD_EN
    if (w) begin
      if (p[31]) return 64'hFFFF_FFFF_0000_0000 + {32'h0, p[31:0]};
      return {32'h0, p[31:0]};
    end
`endif
    return p;
  endfunction

  function automatic logic [63:0] exp_data();
    if (mq.size() == 0) return 64'h0;
    return mq[0].d;
  endfunction

  function automatic logic [TAGW-1:0] exp_rd();
    if (mq.size() == 0) return '0;
    return mq[0].rd;
  endfunction

  task automatic drive(input logic v, input logic [63:0] p, input logic [TAGW-1:0] r,
                       input logic w, input logic ordy, input logic fl);
    in_valid   = v;
    in_product = p;
    in_rd      = r;
    in_word    = w;
    out_ready  = ordy;
    flush      = fl;
  endtask

  // One clock: model decides from its own occupancy, then both advance.
  task automatic tick();
    bit   acc, pp;
    ent_t e;
    acc  = in_valid && (mq.size() < DEPTH);
    pp   = (mq.size() != 0) && out_ready;
    e.d  = model_value(in_product, in_word);
    e.rd = in_rd;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc && in_rd != '0) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_rd !== '0) begin errors++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
  endtask

  task automatic test_single_push();
    drive(1, 64'h15, 5'd3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 64'h15) begin errors++; $display("FAIL single_data got=%h exp=15", out_data); end
    checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL single_rd got=%0d exp=3", out_rd); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    tick();
    checks++; if (out_data !== 64'h15) begin errors++; $display("FAIL single_hold got=%h exp=15", out_data); end
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (count !== '0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL single_pop_data got=%h exp=0", out_data); end
  endtask

  task automatic test_fill();
    drive(1, 64'hA0A0, 5'd5, 0, 0, 0); tick();
    drive(1, 64'hB0B0, 5'd6, 0, 0, 0); tick();
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL fill_count got=%0d exp=2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    drive(1, 64'hC0C0, 5'd7, 0, 0, 0); tick();
    checks++; if (count !== CW'(2) || out_data !== 64'hA0A0) begin
      errors++; $display("FAIL fill_third count=%0d data=%h exp count=2 data=a0a0", count, out_data); end
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_same_cycle got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got=%b exp=1", in_ready); end
    checks++; if (out_data !== 64'hB0B0 || out_rd !== 5'd6) begin
      errors++; $display("FAIL fill_order data=%h rd=%0d exp data=b0b0 rd=6", out_data, out_rd); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_push_pop();
    drive(1, {$urandom, $urandom}, 5'd1, 0, 0, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, {$urandom, $urandom}, TAGW'($urandom_range(1, 31)), 0, 1, 0);
      tick();
      checks++; if (count !== CW'(1)) begin errors++; $display("FAIL pushpop_count[%0d] got=%0d exp=1", i, count); end
      checks++; if (out_data !== exp_data() || out_rd !== exp_rd()) begin
        errors++; $display("FAIL pushpop_data[%0d] got=%h/%0d exp=%h/%0d", i, out_data, out_rd, exp_data(), exp_rd()); end
    end
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_x0_drop();
    drive(1, 64'hFF, 5'd0, 0, 0, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", in_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (count !== '0) begin errors++; $display("FAIL x0_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL x0_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_word();
    logic [63:0] exp;
`ifdef MUL_WB_WORD_EN
    exp = 64'hFFFF_FFFF_8000_0001;
`else
    exp = 64'h1234_5678_8000_0001;
`endif
    drive(1, 64'h1234_5678_8000_0001, 5'd9, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_data !== exp) begin errors++; $display("FAIL word_data got=%h exp=%h", out_data, exp); end
    drive(0, 0, 0, 0, 1, 0); tick();
    drive(1, 64'h0000_0000_7FFF_FFFF, 5'd9, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (out_data !== 64'h7FFF_FFFF) begin errors++; $display("FAIL word_pos got=%h exp=7fffffff", out_data); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_rst();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 64'h1111, 5'd2, 0, 0, 0); tick();
      drive(1, 64'h2222, 5'd4, 0, 0, 0); tick();
      drive(1, 64'h3333, 5'd8, 0, 1, pass == 0);
      rst = (pass == 1);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (count !== '0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL clear%0d count=%0d valid=%b exp 0/0", pass, count, out_valid); end
      checks++; if (out_data !== 64'h0 || out_rd !== '0) begin
        errors++; $display("FAIL clear%0d_out data=%h rd=%0d exp 0/0", pass, out_data, out_rd); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear%0d_discard got=%b exp=0", pass, out_valid); end
      drive(1, 64'h4444, 5'd10, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (out_data !== 64'h4444 || out_rd !== 5'd10) begin
        errors++; $display("FAIL clear%0d_reuse data=%h rd=%0d exp 4444/10", pass, out_data, out_rd); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
            ($urandom_range(0, 5) == 0) ? '0 : TAGW'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 30) == 0);
      tick();
      checks++; if (count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_state[%0d] count=%0d ready=%b valid=%b exp count=%0d", i, count, in_ready, out_valid, mq.size()); end
      checks++; if (out_data !== exp_data() || out_rd !== exp_rd()) begin
        errors++; $display("FAIL rand_head[%0d] got=%h/%0d exp=%h/%0d", i, out_data, out_rd, exp_data(), exp_rd()); end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_single_push();
    test_fill();
    test_push_pop();
    test_x0_drop();
    test_word();
    test_flush_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
